// File: rtl/axi_slv_req_arb.sv
// rtl/axi_slv_req_arb.sv - two-requester round-robin arbiter with burst lock and response timeout
module axi_slv_req_arb #(
  parameter int abits          = 48,
  parameter int dbits          = 64,
  parameter int timeout_cycles = 1024
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_m0_req_valid,
  input  logic [abits-1:0]   i_m0_req_addr,
  input  logic               i_m0_req_write,
  input  logic [dbits-1:0]   i_m0_req_wdata,
  input  logic [dbits/8-1:0] i_m0_req_wstrb,
  input  logic [7:0]         i_m0_req_bytes,
  input  logic               i_m0_req_last,
  output logic               o_m0_req_ready,
  output logic               o_m0_resp_valid,
  output logic [dbits-1:0]   o_m0_resp_rdata,
  output logic               o_m0_resp_err,
  input  logic               i_m1_req_valid,
  input  logic [abits-1:0]   i_m1_req_addr,
  input  logic               i_m1_req_write,
  input  logic [dbits-1:0]   i_m1_req_wdata,
  input  logic [dbits/8-1:0] i_m1_req_wstrb,
  input  logic [7:0]         i_m1_req_bytes,
  input  logic               i_m1_req_last,
  output logic               o_m1_req_ready,
  output logic               o_m1_resp_valid,
  output logic [dbits-1:0]   o_m1_resp_rdata,
  output logic               o_m1_resp_err,
  output logic               o_req_valid,
  output logic [abits-1:0]   o_req_addr,
  output logic               o_req_write,
  output logic [dbits-1:0]   o_req_wdata,
  output logic [dbits/8-1:0] o_req_wstrb,
  output logic [7:0]         o_req_bytes,
  output logic               o_req_last,
  input  logic               i_req_ready,
  input  logic               i_resp_valid,
  input  logic [dbits-1:0]   i_resp_rdata,
  input  logic               i_resp_err
);

  localparam bit          TMO_EN   = (timeout_cycles != 0);
  localparam logic [15:0] TMO_LAST = 16'(timeout_cycles - 1);

  logic        r_wait_resp;
  logic        r_owner;
  logic        r_locked;
  logic        r_beat_last;
  logic        r_prio;
  logic        r_hold;
  logic        r_hold_sel;
  logic [15:0] r_tmo_cnt;

  logic             w_sel;
  logic             w_accept;
  logic             w_resp;
  logic             w_tmo;
  logic             w_done;
  logic [dbits-1:0] w_rdata;
  logic             w_err;

  // A refused beat pins the grant so the target never sees the request switch under it.
  always_comb begin
    w_sel = 1'b0;
    if (r_hold)
      w_sel = r_hold_sel;
    else if (r_locked)
      w_sel = r_owner;
    else if (i_m0_req_valid && i_m1_req_valid)
      w_sel = r_prio;
    else
      w_sel = i_m1_req_valid;
  end

  assign o_req_valid = (w_sel ? i_m1_req_valid : i_m0_req_valid) & ~r_wait_resp;
  assign o_req_addr  = w_sel ? i_m1_req_addr  : i_m0_req_addr;
  assign o_req_write = w_sel ? i_m1_req_write : i_m0_req_write;
  assign o_req_wdata = w_sel ? i_m1_req_wdata : i_m0_req_wdata;
  assign o_req_wstrb = w_sel ? i_m1_req_wstrb : i_m0_req_wstrb;
  assign o_req_bytes = w_sel ? i_m1_req_bytes : i_m0_req_bytes;
  assign o_req_last  = w_sel ? i_m1_req_last  : i_m0_req_last;

  assign o_m0_req_ready = ~w_sel & i_req_ready & ~r_wait_resp;
  assign o_m1_req_ready =  w_sel & i_req_ready & ~r_wait_resp;

  assign w_accept = o_req_valid & i_req_ready;
  assign w_resp   = r_wait_resp & i_resp_valid;
  assign w_tmo    = TMO_EN && r_wait_resp && !i_resp_valid && (r_tmo_cnt == TMO_LAST);
  assign w_done   = w_resp | w_tmo;
  assign w_rdata  = w_resp ? i_resp_rdata : '0;
  assign w_err    = w_tmo | (w_resp & i_resp_err);

  assign o_m0_resp_valid = w_done & ~r_owner;
  assign o_m1_resp_valid = w_done &  r_owner;
  assign o_m0_resp_rdata = o_m0_resp_valid ? w_rdata : '0;
  assign o_m1_resp_rdata = o_m1_resp_valid ? w_rdata : '0;
  assign o_m0_resp_err   = o_m0_resp_valid & w_err;
  assign o_m1_resp_err   = o_m1_resp_valid & w_err;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_wait_resp <= 1'b0;
      r_owner     <= 1'b0;
      r_locked    <= 1'b0;
      r_beat_last <= 1'b0;
      r_prio      <= 1'b0;
      r_hold      <= 1'b0;
      r_hold_sel  <= 1'b0;
      r_tmo_cnt   <= 16'd0;
    end else if (r_wait_resp) begin
      if (w_resp) begin
        r_wait_resp <= 1'b0;
        r_tmo_cnt   <= 16'd0;
        if (r_beat_last) begin
          r_locked <= 1'b0;
          r_prio   <= ~r_owner;
        end
      end else if (w_tmo) begin
        // A timed-out beat aborts the rest of its burst.
        r_wait_resp <= 1'b0;
        r_tmo_cnt   <= 16'd0;
        r_locked    <= 1'b0;
        r_prio      <= ~r_owner;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
    end else begin
      r_tmo_cnt <= 16'd0;
      if (w_accept) begin
        r_owner     <= w_sel;
        r_wait_resp <= 1'b1;
        r_beat_last <= o_req_last;
        r_locked    <= ~o_req_last;
        r_hold      <= 1'b0;
      end else if (o_req_valid) begin
        r_hold     <= 1'b1;
        r_hold_sel <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_axi_slv_req_arb.sv
// tb/tb_axi_slv_req_arb.sv - directed bench with a transaction-level model of the arbiter
module tb_axi_slv_req_arb;

  localparam int AB  = 48;
  localparam int DB  = 64;
  localparam int SB  = DB / 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          nrst;
  logic [1:0]    m_valid, m_write, m_last;
  logic [AB-1:0] m_addr [2];
  logic [DB-1:0] m_wdata[2];
  logic [SB-1:0] m_wstrb[2];
  logic [7:0]    m_bytes[2];
  logic [1:0]    m_ready, r_valid, r_err;
  logic [DB-1:0] r_rdata[2];
  logic          q_valid, q_write, q_last;
  logic [AB-1:0] q_addr;
  logic [DB-1:0] q_wdata;
  logic [SB-1:0] q_wstrb;
  logic [7:0]    q_bytes;
  logic          t_ready, t_rvalid, t_rerr;
  logic [DB-1:0] t_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  axi_slv_req_arb #(.abits(AB), .dbits(DB), .timeout_cycles(TMO)) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_m0_req_valid(m_valid[0]), .i_m0_req_addr(m_addr[0]), .i_m0_req_write(m_write[0]),
    .i_m0_req_wdata(m_wdata[0]), .i_m0_req_wstrb(m_wstrb[0]), .i_m0_req_bytes(m_bytes[0]),
    .i_m0_req_last(m_last[0]), .o_m0_req_ready(m_ready[0]), .o_m0_resp_valid(r_valid[0]),
    .o_m0_resp_rdata(r_rdata[0]), .o_m0_resp_err(r_err[0]),
    .i_m1_req_valid(m_valid[1]), .i_m1_req_addr(m_addr[1]), .i_m1_req_write(m_write[1]),
    .i_m1_req_wdata(m_wdata[1]), .i_m1_req_wstrb(m_wstrb[1]), .i_m1_req_bytes(m_bytes[1]),
    .i_m1_req_last(m_last[1]), .o_m1_req_ready(m_ready[1]), .o_m1_resp_valid(r_valid[1]),
    .o_m1_resp_rdata(r_rdata[1]), .o_m1_resp_err(r_err[1]),
    .o_req_valid(q_valid), .o_req_addr(q_addr), .o_req_write(q_write), .o_req_wdata(q_wdata),
    .o_req_wstrb(q_wstrb), .o_req_bytes(q_bytes), .o_req_last(q_last),
    .i_req_ready(t_ready), .i_resp_valid(t_rvalid), .i_resp_rdata(t_rdata), .i_resp_err(t_rerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: who owns the burst, who is stuck presenting, and the age of the outstanding beat.
  bit model_on = 1'b0;
  int mb_owner = -1;
  int m_present = -1;
  bit m_out = 1'b0;
  int m_out_owner = 0;
  bit m_out_last = 1'b0;
  int m_age = 0;
  int m_pref = 0;
  int e_p;
  bit e_v, e_rsp, e_tmo, e_rv;

  always @(negedge clk) begin
    if (m_present >= 0)                 e_p = m_present;
    else if (mb_owner >= 0)             e_p = mb_owner;
    else if (m_valid == 2'b11)          e_p = m_pref;
    else                                e_p = m_valid[1] ? 1 : 0;
    e_v   = m_valid[e_p] && !m_out;
    e_rsp = m_out && t_rvalid;
    e_tmo = m_out && !t_rvalid && (TMO != 0) && (m_age == TMO);
    if (model_on) begin
      check("req_valid", 64'(q_valid), 64'(e_v));
      check("req_addr",  64'(q_addr),  64'(m_addr[e_p]));
      check("req_write", 64'(q_write), 64'(m_write[e_p]));
      check("req_wdata", q_wdata,      m_wdata[e_p]);
      check("req_wstrb", 64'(q_wstrb), 64'(m_wstrb[e_p]));
      check("req_bytes", 64'(q_bytes), 64'(m_bytes[e_p]));
      check("req_last",  64'(q_last),  64'(m_last[e_p]));
      for (int n = 0; n < 2; n++) begin
        check($sformatf("m%0d_req_ready", n), 64'(m_ready[n]), 64'((n == e_p) && t_ready && !m_out));
        e_rv = (e_rsp || e_tmo) && (m_out_owner == n);
        check($sformatf("m%0d_resp_valid", n), 64'(r_valid[n]), 64'(e_rv));
        if (e_rv) begin
          check($sformatf("m%0d_resp_err", n), 64'(r_err[n]), 64'(e_tmo ? 1'b1 : t_rerr));
          check($sformatf("m%0d_resp_rdata", n), r_rdata[n], e_tmo ? 64'd0 : t_rdata);
        end
      end
    end
    if (!nrst) begin
      model_on = 1'b1; mb_owner = -1; m_present = -1; m_out = 1'b0;
      m_out_owner = 0; m_out_last = 1'b0; m_age = 0; m_pref = 0;
    end else if (m_out) begin
      if (e_rsp) begin
        m_out = 1'b0;
        if (m_out_last) begin mb_owner = -1; m_pref = 1 - m_out_owner; end
      end else if (e_tmo) begin
        m_out = 1'b0; mb_owner = -1; m_pref = 1 - m_out_owner;
      end else begin
        m_age++;
      end
    end else if (e_v && t_ready) begin
      m_out = 1'b1; m_out_owner = e_p; m_out_last = m_last[e_p];
      mb_owner = m_last[e_p] ? -1 : e_p; m_present = -1; m_age = 1;
    end else if (e_v) begin
      m_present = e_p;
    end
  end

  logic [1:0]    o_acc, o_rv, o_rerr;
  logic          o_qv;
  logic [DB-1:0] o_rd[2];
  logic [AB-1:0] o_addr;

  task automatic step();
    @(negedge clk);
    o_acc = m_ready & m_valid; o_rv = r_valid; o_rerr = r_err; o_qv = q_valid;
    o_rd[0] = r_rdata[0]; o_rd[1] = r_rdata[1]; o_addr = q_addr;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step_auto();
    step();
    t_rvalid = |o_acc;
    t_rdata  = {32'hD00D_0000, 32'(cyc)};
    t_rerr   = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0; step(); nrst = 1'b1;
  endtask

  int gq[$], tq[$];
  int beats, b4, m0_acc, acc_c, seen;

  initial begin
    nrst = 1'b0; m_valid = '0; m_write = '0; m_last = '0;
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0; m_wdata[n] = '0; m_wstrb[n] = '0; m_bytes[n] = '0;
    end
    t_ready = 1'b0; t_rvalid = 1'b0; t_rerr = 1'b0; t_rdata = '0;
    step(); step();
    check("reset req_valid", 64'(o_qv), 64'd0);
    check("reset resp_valid", 64'(o_rv), 64'd0);
    nrst = 1'b1;

    // single read with a 3-cycle response
    m_valid[0] = 1'b1; m_addr[0] = 48'h1000; m_last[0] = 1'b1; m_bytes[0] = 8'd8;
    m_wstrb[0] = 8'hFF; t_ready = 1'b1;
    step();
    check("t1 accept", 64'(o_acc), 64'd1);
    check("t1 addr", 64'(o_addr), 64'h1000);
    m_valid[0] = 1'b0;
    step(); step();
    check("t1 early resp", 64'(o_rv), 64'd0);
    t_rvalid = 1'b1; t_rdata = 64'h1122334455667788;
    step();
    check("t1 resp_valid", 64'(o_rv), 64'd1);
    check("t1 rdata", o_rd[0], 64'h1122334455667788);
    t_rvalid = 1'b0;

    // fairness after reset
    do_reset();
    m_valid = 2'b11; m_last = 2'b11; m_addr[0] = 48'h2000; m_addr[1] = 48'h3000;
    for (int i = 0; i < 8; i++) begin
      step_auto();
      if (o_acc[0]) begin gq.push_back(0); tq.push_back(cyc - 1); end
      if (o_acc[1]) begin gq.push_back(1); tq.push_back(cyc - 1); end
    end
    m_valid = 2'b00;
    step_auto();
    check("t2 grant count", 64'(gq.size()), 64'd4);
    for (int i = 0; i < gq.size() && i < 4; i++) begin
      check($sformatf("t2 grant %0d", i), 64'(gq[i]), 64'(i % 2));
      if (i > 0) check($sformatf("t2 spacing %0d", i), 64'(tq[i] - tq[i-1]), 64'd2);
    end

    // burst lock: m1 4-beat write burst, m0 arrives during beat 2
    beats = 0; b4 = -100; m0_acc = -1;
    m_valid[1] = 1'b1; m_last[1] = 1'b0; m_write[1] = 1'b1; m_addr[1] = 48'h4000;
    m_wdata[1] = 64'hA5A5_0000_0000_0001; m_wstrb[1] = 8'h0F; m_bytes[1] = 8'd4;
    for (int i = 0; i < 20; i++) begin
      step_auto();
      if (o_acc[0]) begin m0_acc = cyc - 1; m_valid[0] = 1'b0; end
      if (o_acc[1]) begin
        beats++;
        if (beats == 4) begin b4 = cyc - 1; m_valid[1] = 1'b0; end
        m_addr[1] = m_addr[1] + 48'd8; m_wdata[1] = m_wdata[1] + 64'd1;
        m_last[1] = (beats == 3);
        if (beats == 2) begin m_valid[0] = 1'b1; m_addr[0] = 48'h5000; m_last[0] = 1'b1; end
      end
    end
    check("t3 m1 beats", 64'(beats), 64'd4);
    check("t3 m0 after burst", 64'(m0_acc - b4), 64'd2);

    // backpressure hold
    do_reset();
    m_write = 2'b00;
    m_valid[1] = 1'b1; m_addr[1] = 48'h6000; m_last[1] = 1'b1; t_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin m_valid[0] = 1'b1; m_addr[0] = 48'h7000; m_last[0] = 1'b1; end
      step();
      check($sformatf("t4 held addr %0d", i), 64'(o_addr), 64'h6000);
      check($sformatf("t4 no accept %0d", i), 64'(o_acc), 64'd0);
    end
    t_ready = 1'b1;
    step();
    check("t4 m1 accept", 64'(o_acc), 64'd2);
    check("t4 m1 addr", 64'(o_addr), 64'h6000);
    m_valid[1] = 1'b0; t_rvalid = 1'b1;
    step();
    t_rvalid = 1'b0;
    step();
    check("t4 m0 accept", 64'(o_acc), 64'd1);
    m_valid[0] = 1'b0; t_rvalid = 1'b1;
    step();
    t_rvalid = 1'b0;

    // timeout on an m0 write beat that opens a burst
    m_valid[0] = 1'b1; m_write[0] = 1'b1; m_last[0] = 1'b0; m_addr[0] = 48'h8000;
    m_wdata[0] = 64'hFEED_FACE_0BAD_F00D;
    step();
    check("t5 accept", 64'(o_acc), 64'd1);
    acc_c = cyc - 1; m_valid[0] = 1'b0; seen = -1;
    for (int i = 0; i < 40 && seen < 0; i++) begin
      step();
      if (o_rv[0]) begin
        seen = cyc - 1;
        check("t5 tmo err", 64'(o_rerr[0]), 64'd1);
        check("t5 tmo rdata", o_rd[0], 64'd0);
      end
    end
    check("t5 tmo latency", 64'(seen - acc_c), 64'(TMO));
    step(); step(); step();
    t_rvalid = 1'b1; t_rdata = 64'h0123_4567_89AB_CDEF;
    step();
    check("t5 late resp dropped", 64'(o_rv), 64'd0);
    t_rvalid = 1'b0;
    m_valid[1] = 1'b1; m_addr[1] = 48'h9000; m_last[1] = 1'b1;
    step();
    check("t5 lock released", 64'(o_acc), 64'd2);
    m_valid[1] = 1'b0; t_rvalid = 1'b1;
    step();
    t_rvalid = 1'b0;

    // reset in the middle of an m0 burst
    m_write = 2'b00;
    m_valid[0] = 1'b1; m_last[0] = 1'b1; m_addr[0] = 48'hA000;
    step_auto();
    m_valid[0] = 1'b0;
    step_auto();
    m_valid[0] = 1'b1; m_last[0] = 1'b0; m_addr[0] = 48'hB000;
    step_auto(); step_auto(); step_auto();
    check("t6 beat2 accept", 64'(o_acc), 64'd1);
    t_rvalid = 1'b0; m_valid[0] = 1'b0; nrst = 1'b0;
    step();
    check("t6 reset resp", 64'(o_rv), 64'd0);
    nrst = 1'b1; t_rvalid = 1'b1;
    step();
    check("t6 stale resp dropped", 64'(o_rv), 64'd0);
    t_rvalid = 1'b0;
    m_valid[1] = 1'b1; m_last[1] = 1'b1; m_addr[1] = 48'hC000;
    step_auto();
    check("t6 lock cleared", 64'(o_acc), 64'd2);
    m_valid[1] = 1'b0;
    step_auto();
    do_reset();
    m_valid = 2'b11; m_last = 2'b11;
    step_auto();
    check("t6 prio after reset", 64'(o_acc), 64'd1);
    m_valid = 2'b00;
    step_auto(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
